// File: rtl/adder_counter_mux_pkg.sv
// Shared widths and output-select encoding for the adder/counter/mux datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: OPERAND_W, ACC_W, CNT_W width constants; sel_e select enum.
package adder_counter_mux_pkg;

   localparam int OPERAND_W = 8;
   localparam int ACC_W     = 16;   // accumulator is two operand bytes wide
   localparam int CNT_W     = 8;

   typedef enum logic [1:0] {
      SEL_ACC_LSB = 2'b00,
      SEL_ACC_MSB = 2'b01,
      SEL_COUNT   = 2'b10,
      SEL_CARRY   = 2'b11
   } sel_e;

endpackage

// File: rtl/adder_counter_mux_if.sv
// Bus bundle between the operand/accumulator registers and the datapath core.
// Latency: n/a (wires only).
// Backpressure: none; the add strobe is a plain enable with no ready path.
// Modports: slave = datapath core (consumes add/operand/acc/sel, drives results);
//           master = surrounding logic (drives add/operand/acc/sel, reads results).
interface adder_counter_mux_if
   import adder_counter_mux_pkg::*;
#(
   parameter int OPERAND_WIDTH = OPERAND_W,
   parameter int ACC_WIDTH     = ACC_W,
   parameter int COUNT_WIDTH   = CNT_W
);
   logic                     add;
   logic [OPERAND_WIDTH-1:0] new_operand;
   logic [ACC_WIDTH-1:0]     current_value;
   logic [ACC_WIDTH-1:0]     output_value;
   logic [1:0]               sel;
   logic [OPERAND_WIDTH-1:0] data_out;
   logic [COUNT_WIDTH-1:0]   counter_value;
   logic                     counter_carry;

   modport slave (
      input  add, new_operand, current_value, sel,
      output output_value, data_out, counter_value, counter_carry
   );

   modport master (
      output add, new_operand, current_value, sel,
      input  output_value, data_out, counter_value, counter_carry
   );
endinterface

// File: rtl/adder_counter_mux_add_counter.sv
// Counts add strobes; sticky flag records that the count has ever wrapped.
// Latency: count/carry update on the rising clock edge that samples add=1.
// Backpressure: none; add=0 simply holds state.
// Ports: clock, reset (async active-low), add (in), count (out), carry (out).
module add_counter
   import adder_counter_mux_pkg::*;
#(
   parameter int COUNT_WIDTH = CNT_W
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   add,
   output logic [COUNT_WIDTH-1:0] count,
   output logic                   carry
);
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count <= '0;
         carry <= 1'b0;
      end else if (add) begin
         count <= count + COUNT_WIDTH'(1);
         // Set on the edge that wraps all-ones to zero; only reset clears it.
         if (&count) begin
            carry <= 1'b1;
         end
      end
   end
endmodule

// File: rtl/adder_counter_mux_adder_comb.sv
// Accumulator adder: current_value + zero-extended operand, carry out dropped.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: operand (in), acc (in), sum (out).
module adder_comb
   import adder_counter_mux_pkg::*;
#(
   parameter int OPERAND_WIDTH = OPERAND_W,
   parameter int ACC_WIDTH     = ACC_W
) (
   input  logic [OPERAND_WIDTH-1:0] operand,
   input  logic [ACC_WIDTH-1:0]     acc,
   output logic [ACC_WIDTH-1:0]     sum
);
   // Result is truncated to the accumulator width, so 0xFFFF + 1 wraps to 0.
   assign sum = acc + {{(ACC_WIDTH-OPERAND_WIDTH){1'b0}}, operand};
endmodule

// File: rtl/adder_counter_mux_out_mux4.sv
// Byte-wide 4:1 output select: acc LSB, acc MSB, count, or carry flag.
// Latency: 0 cycles (combinational; sel acts in the same cycle).
// Backpressure: none.
// Ports: sel, acc, count, carry (in); data (out).
module out_mux4
   import adder_counter_mux_pkg::*;
#(
   parameter int OPERAND_WIDTH = OPERAND_W,
   parameter int ACC_WIDTH     = ACC_W,
   parameter int COUNT_WIDTH   = CNT_W
) (
   input  logic [1:0]               sel,
   input  logic [ACC_WIDTH-1:0]     acc,
   input  logic [COUNT_WIDTH-1:0]   count,
   input  logic                     carry,
   output logic [OPERAND_WIDTH-1:0] data
);
   always_comb begin
      data = '0;
      case (sel_e'(sel))
         SEL_ACC_LSB: data = acc[OPERAND_WIDTH-1:0];
         SEL_ACC_MSB: data = acc[ACC_WIDTH-1:OPERAND_WIDTH];
         SEL_COUNT:   data = OPERAND_WIDTH'(count);
         SEL_CARRY:   data = OPERAND_WIDTH'(carry);   // flag in bit 0, rest zero
         default:     data = '0;
      endcase
   end
endmodule

// File: rtl/adder_counter_mux.sv
// Datapath core between operand and accumulator registers: adder, add counter, output mux.
// Latency: sum and mux are 0-cycle; counter updates on the clock edge sampling add.
// Backpressure: none; add is a plain enable shared with the external accumulator load.
// Ports: clock, reset (async active-low), bus (slave: add, new_operand, current_value,
//        sel in; output_value, data_out, counter_value, counter_carry out).
// ACC_WIDTH must equal 2*OPERAND_WIDTH so the mux can split the accumulator into bytes.
module adder_counter_mux
   import adder_counter_mux_pkg::*;
#(
   parameter int OPERAND_WIDTH = OPERAND_W,
   parameter int ACC_WIDTH     = ACC_W,
   parameter int COUNT_WIDTH   = CNT_W
) (
   input  logic                clock,
   input  logic                reset,
   adder_counter_mux_if.slave  bus
);
   logic [COUNT_WIDTH-1:0] count;
   logic                   carry;

   adder_comb #(
      .OPERAND_WIDTH (OPERAND_WIDTH),
      .ACC_WIDTH     (ACC_WIDTH)
   ) u_adder (
      .operand (bus.new_operand),
      .acc     (bus.current_value),
      .sum     (bus.output_value)
   );

   add_counter #(
      .COUNT_WIDTH (COUNT_WIDTH)
   ) u_counter (
      .clock (clock),
      .reset (reset),
      .add   (bus.add),
      .count (count),
      .carry (carry)
   );

   out_mux4 #(
      .OPERAND_WIDTH (OPERAND_WIDTH),
      .ACC_WIDTH     (ACC_WIDTH),
      .COUNT_WIDTH   (COUNT_WIDTH)
   ) u_mux (
      .sel   (bus.sel),
      .acc   (bus.current_value),
      .count (count),
      .carry (carry),
      .data  (bus.data_out)
   );

   assign bus.counter_value = count;
   assign bus.counter_carry = carry;
endmodule

// File: tb/tb_adder_counter_mux.sv
// Directed bench for adder_counter_mux: combinational vector table plus counter sequences.
module tb_adder_counter_mux;
   import adder_counter_mux_pkg::*;

   logic clock;
   logic reset;
   int   checks;
   int   failures;

   adder_counter_mux_if bus ();

   adder_counter_mux dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [7:0]  op;
      logic [15:0] cur;
      logic [1:0]  sel;
      logic [15:0] exp_sum;
      logic [7:0]  exp_out;
   } vec_t;

   vec_t vecs [7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Advance one clock edge, then settle 1 time unit past it before sampling.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   logic [15:0] acc_reg;
   logic [15:0] acc_model;
   logic [15:0] nxt;
   logic [7:0]  op;

   initial begin
      checks   = 0;
      failures = 0;

      vecs[0] = '{8'h05, 16'h00FE, 2'b00, 16'h0103, 8'hFE};
      vecs[1] = '{8'h01, 16'hFFFF, 2'b01, 16'h0000, 8'hFF};
      vecs[2] = '{8'h00, 16'hA55A, 2'b00, 16'hA55A, 8'h5A};
      vecs[3] = '{8'h00, 16'hA55A, 2'b01, 16'hA55A, 8'hA5};
      vecs[4] = '{8'hFF, 16'h0001, 2'b10, 16'h0100, 8'h00};
      vecs[5] = '{8'h80, 16'h7F80, 2'b11, 16'h8000, 8'h00};
      vecs[6] = '{8'hFF, 16'hFF00, 2'b00, 16'hFFFF, 8'h00};

      // ---- reset state ----
      reset             = 1'b0;
      bus.add           = 1'b0;
      bus.new_operand   = 8'h00;
      bus.current_value = 16'h0000;
      bus.sel           = 2'b10;
      #3;
      check("rst_sel10_data", 32'(bus.data_out), 32'h00);
      bus.sel = 2'b11;
      #1;
      check("rst_sel11_data", 32'(bus.data_out), 32'h00);
      bus.sel = 2'b00;
      #1;
      check("rst_sel00_data", 32'(bus.data_out), 32'h00);
      bus.sel = 2'b01;
      #1;
      check("rst_sel01_data", 32'(bus.data_out), 32'h00);
      check("rst_count", 32'(bus.counter_value), 32'h00);
      check("rst_carry", 32'(bus.counter_carry), 32'h0);

      // Reset held across a clock edge with add=1 must keep the counter at 0.
      bus.add = 1'b1;
      tick();
      check("rst_hold_count", 32'(bus.counter_value), 32'h00);
      bus.add = 1'b0;
      #2 reset = 1'b1;
      tick();

      // ---- combinational table (add=0, counter=0, carry=0) ----
      for (int i = 0; i < 7; i++) begin
         bus.new_operand   = vecs[i].op;
         bus.current_value = vecs[i].cur;
         bus.sel           = vecs[i].sel;
         #1;
         check($sformatf("vec%0d_sum", i), 32'(bus.output_value), 32'(vecs[i].exp_sum));
         check($sformatf("vec%0d_out", i), 32'(bus.data_out), 32'(vecs[i].exp_out));
      end

      // ---- counter: 3 adds then 2 holds ----
      bus.add = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         tick();
         check($sformatf("cnt_add%0d", i), 32'(bus.counter_value), 32'(i));
      end
      bus.add = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         check($sformatf("cnt_hold%0d", i), 32'(bus.counter_value), 32'h03);
      end
      bus.sel = 2'b10;
      #1;
      check("cnt_sel10_data", 32'(bus.data_out), 32'h03);
      check("cnt_no_carry", 32'(bus.counter_carry), 32'h0);

      // ---- wrap: fresh reset, 257 adds with an emulated accumulator ----
      #1 reset = 1'b0;
      #1 reset = 1'b1;
      acc_reg   = 16'h0000;
      acc_model = 16'h0000;
      bus.add   = 1'b1;
      for (int i = 1; i <= 257; i++) begin
         op                = 8'(i * 7 + 3);
         bus.new_operand   = op;
         bus.current_value = acc_reg;
         #1;
         nxt = bus.output_value;
         tick();
         acc_reg   = nxt;
         acc_model = acc_model + {8'h00, op};
         check($sformatf("wrap_cnt%0d", i), 32'(bus.counter_value), 32'(i % 256));
         if (i == 255 || i == 256 || i == 257)
            check($sformatf("wrap_carry%0d", i), 32'(bus.counter_carry), 32'(i >= 256));
         if (i == 256) begin
            bus.sel = 2'b11;
            #1;
            check("wrap_sel11_data", 32'(bus.data_out), 32'h01);
         end
      end
      check("acc_alignment", 32'(acc_reg), 32'(acc_model));

      // ---- reset mid-count: bring counter to 0x10 with carry set ----
      for (int i = 0; i < 15; i++) tick();
      check("mid_cnt_pre", 32'(bus.counter_value), 32'h10);
      check("mid_carry_pre", 32'(bus.counter_carry), 32'h1);
      #2 reset = 1'b0;
      #1;
      check("mid_cnt_cleared", 32'(bus.counter_value), 32'h00);
      check("mid_carry_cleared", 32'(bus.counter_carry), 32'h0);
      #1 reset = 1'b1;
      tick();
      check("mid_resume_cnt", 32'(bus.counter_value), 32'h01);
      check("mid_resume_carry", 32'(bus.counter_carry), 32'h0);
      bus.sel = 2'b10;
      #1;
      check("mid_resume_data", 32'(bus.data_out), 32'h01);

      bus.add = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
